pci_data_phase: RTL and testbench
=================================

Name: pci_data_phase

Overview:
- Downstream stage of the PCI address-phase state machine; sits in U109.
- Takes ownership of a PCI cycle once the address phase has been driven (PCI_CYCLEn low).
- Runs the data phase: drives IRDYn, counts burst beats, ends FRAME on the last beat, and detects master abort, target abort, retry and disconnect.
- Returns TACKn/TEAn to the 68040 side.

Parameters:
- DEVSEL_TIMEOUT, 5: CLK33 edges after cycle start with no DEVSELn before master abort.
- TRDY_TIMEOUT, 16: CLK33 edges in DATA with no TRDYn/STOPn before latency abort.

Ports:
- CLK33  in  1  PCI clock; all logic on rising edge.
- RESETn  in  1  reset, asynchronous, active-low.
- PCI_CYCLEn  in  1  low = address phase driven by the upstream stage; held low until DONE.
- BURST  in  1  1 = four-longword line transfer; sampled with cycle start.
- RnW  in  1  1 = read; sampled with cycle start.
- DEVSELn  in  1  PCI target select.
- TRDYn  in  1  PCI target ready.
- STOPn  in  1  PCI target stop.
- IRDYn  out  1  PCI initiator ready.
- LAST_BEAT  out  1  1 = upstream must deassert FRAMEn now.
- DATA_LE  out  1  one-clock read-data latch enable.
- BEAT  out  2  current beat index, 0..3.
- TACKn  out  1  one-clock transfer acknowledge per completed beat.
- TEAn  out  1  one-clock transfer error.
- RETRY  out  1  one-clock pulse: cycle must be re-run.
- DONE  out  1  one-clock pulse: cycle finished and bus released.

Behaviour:
- Reset values: IRDYn=1, LAST_BEAT=0, DATA_LE=0, BEAT=0, TACKn=1, TEAn=1, RETRY=0, DONE=0, state=IDLE, counters=0.
- Reset asserted mid-cycle aborts the cycle immediately: all outputs return to reset values and no DONE is emitted.
- All PCI inputs are sampled on the rising edge of CLK33; all outputs are registered.

State machine:
- IDLE: on a PCI_CYCLEn falling edge (registered previous value = 1), latch BURST and RnW, clear counters, go to WAIT_DEVSEL, set IRDYn=0.
  - LAST_BEAT=1 at that point if BURST=0.
- WAIT_DEVSEL:
  - DEVSELn=0 -> go to DATA. If TRDYn or STOPn is also low on the same edge, evaluate it as a DATA edge.
  - Timeout counter reaches DEVSEL_TIMEOUT -> master abort: TEAn=0 for one clock, LAST_BEAT=1, go to TURNAROUND.
- DATA, edge with IRDYn=0 and TRDYn=0 (beat completes):
  - TACKn=0 and DATA_LE=RnW, each for one clock.
  - If BEAT=3 or BURST=0: go to TURNAROUND.
  - Otherwise: BEAT+1.
  - LAST_BEAT=1 in the clock after BEAT reaches 2 (burst), so FRAMEn drops before the final beat.
  - TRDY timeout counter clears on every completed beat.
- DATA, STOPn=0 with TRDYn=0 (disconnect with data): complete the beat as above.
  - If beats remain, also RETRY=1.
  - Go to TURNAROUND.
- DATA, STOPn=0 with TRDYn=1, DEVSELn=0 (retry/disconnect without data): no TACK; RETRY=1; go to TURNAROUND.
- DATA, STOPn=0 with DEVSELn=1 (target abort): TEAn=0; go to TURNAROUND.
- DATA, TRDY timeout counter reaches TRDY_TIMEOUT: TEAn=0; go to TURNAROUND.
- TURNAROUND: IRDYn=1, LAST_BEAT=0, BEAT=0, DONE=1 for one clock; go to IDLE.
  - A new cycle is not accepted until PCI_CYCLEn has returned high.

Invariants and boundary conditions:
- LAST_BEAT is asserted at least one edge before IRDYn deasserts, and only while IRDYn=0.
- BEAT never wraps; any attempted increment past 3 is a design error and asserts TEAn.
- TACKn and TEAn are never low on the same clock. If error and a completed beat coincide, the beat's TACK wins and the error is reported on the next clock.
- PCI_CYCLEn rising while not in IDLE is ignored until DONE.

Test Plan:
- Single read: PCI_CYCLEn low; DEVSELn low at edge 2; TRDYn low at edge 3 -> one TACKn and one DATA_LE at edge 4; LAST_BEAT high from cycle start; DONE at edge 5.
- Burst write: BURST=1; TRDYn held low -> TACKn four times on consecutive clocks, BEAT 0,1,2,3; LAST_BEAT high before beat 3; DATA_LE never asserted.
- Master abort: DEVSELn held high -> TEAn pulse 5 edges after start; no TACKn; DONE next clock.
- Retry: DEVSELn=0, STOPn=0, TRDYn=1 on first data edge -> RETRY pulse; no TACKn; DONE next clock.
- Disconnect: burst; STOPn and TRDYn low together on beat 1 -> TACKn for beats 0 and 1, RETRY=1, BEAT returns to 0.
- Reset mid-burst at BEAT=2 -> all outputs at reset values immediately; next PCI_CYCLEn fall starts cleanly at BEAT=0.

Source files
------------

// File: rtl/pci_data_phase.sv
// pci_data_phase: PCI initiator data phase, follows the address-phase stage and returns TACKn/TEAn to the 68040 side
//   CLK33, RESETn               PCI clock (rising edge) and asynchronous active-low reset
//   PCI_CYCLEn, BURST, RnW      cycle start from the address stage; BURST/RnW latched at start
//   DEVSELn, TRDYn, STOPn       PCI target responses, sampled on CLK33
//   IRDYn, LAST_BEAT            initiator ready; LAST_BEAT tells upstream to deassert FRAMEn
//   DATA_LE, BEAT               read-data latch enable pulse; current beat index 0..3
//   TACKn, TEAn, RETRY, DONE    one-clock acknowledge, error, re-run request, cycle-finished pulses
module pci_data_phase #(
   parameter int DEVSEL_TIMEOUT = 5,
   parameter int TRDY_TIMEOUT   = 16
) (
   input  logic       CLK33,
   input  logic       RESETn,
   input  logic       PCI_CYCLEn,
   input  logic       BURST,
   input  logic       RnW,
   input  logic       DEVSELn,
   input  logic       TRDYn,
   input  logic       STOPn,
   output logic       IRDYn,
   output logic       LAST_BEAT,
   output logic       DATA_LE,
   output logic [1:0] BEAT,
   output logic       TACKn,
   output logic       TEAn,
   output logic       RETRY,
   output logic       DONE
);
   localparam int MAXT = (DEVSEL_TIMEOUT > TRDY_TIMEOUT) ? DEVSEL_TIMEOUT : TRDY_TIMEOUT;
   localparam int CW   = $clog2(MAXT + 1);
   typedef enum logic [1:0] {IDLE, WAIT_DEVSEL, DATA, TURNAROUND} state_t;
   state_t        state, state_d;
   logic          cyc_q, burst_q, rnw_q, err_pend;
   logic          burst_d, rnw_d, err_pend_d;
   logic [CW-1:0] cnt, cnt_d, cnt_inc;
   logic          irdy_d, last_d, le_d, tack_d, tea_d, retry_d, done_d;
   logic [1:0]    beat_d;
   logic          data_edge, final_beat;
   assign cnt_inc    = cnt + CW'(1);
   // DEVSELn arriving together with TRDYn/STOPn is handled as the first data edge
   assign data_edge  = (state == DATA) || (state == WAIT_DEVSEL && !DEVSELn);
   assign final_beat = (BEAT == 2'd3) || !burst_q;
   always_comb begin
      state_d    = state;
      burst_d    = burst_q;
      rnw_d      = rnw_q;
      cnt_d      = cnt;
      err_pend_d = err_pend;
      irdy_d     = IRDYn;
      last_d     = LAST_BEAT;
      beat_d     = BEAT;
      le_d       = 1'b0;
      tack_d     = 1'b1;
      tea_d      = 1'b1;
      retry_d    = 1'b0;
      done_d     = 1'b0;
      case (state)
         IDLE: if (cyc_q && !PCI_CYCLEn) begin
            state_d    = WAIT_DEVSEL;
            burst_d    = BURST;
            rnw_d      = RnW;
            cnt_d      = '0;
            err_pend_d = 1'b0;
            beat_d     = 2'd0;
            irdy_d     = 1'b0;
            last_d     = !BURST;
         end
         WAIT_DEVSEL: if (DEVSELn) begin
            if (cnt_inc == CW'(DEVSEL_TIMEOUT)) begin
               tea_d   = 1'b0;
               last_d  = 1'b1;
               state_d = TURNAROUND;
            end else
               cnt_d = cnt_inc;
         end
         TURNAROUND: begin
            irdy_d     = 1'b1;
            last_d     = 1'b0;
            beat_d     = 2'd0;
            done_d     = 1'b1;
            // an abort that coincided with a completed beat is reported here, after its TACK
            tea_d      = !err_pend;
            err_pend_d = 1'b0;
            state_d    = IDLE;
         end
         default: ;
      endcase
      if (data_edge) begin
         state_d = DATA;
         if (!TRDYn) begin
            tack_d = 1'b0;
            le_d   = rnw_q;
            cnt_d  = '0;
            if (final_beat || !STOPn) begin
               state_d    = TURNAROUND;
               last_d     = 1'b1;
               retry_d    = !STOPn && !DEVSELn && !final_beat;
               err_pend_d = !STOPn && DEVSELn;
            end else begin
               beat_d = BEAT + 2'd1;
               // FRAMEn must drop one clock ahead of the final beat
               last_d = LAST_BEAT || (BEAT == 2'd1);
            end
         end else if (!STOPn) begin
            state_d = TURNAROUND;
            last_d  = 1'b1;
            retry_d = !DEVSELn;
            tea_d   = !DEVSELn;
         end else if (state == DATA) begin
            if (cnt_inc == CW'(TRDY_TIMEOUT)) begin
               tea_d   = 1'b0;
               last_d  = 1'b1;
               state_d = TURNAROUND;
            end else
               cnt_d = cnt_inc;
         end else
            cnt_d = '0;
      end
   end
   always_ff @(posedge CLK33 or negedge RESETn) begin
      if (!RESETn) begin
         state     <= IDLE;
         cyc_q     <= 1'b0;
         burst_q   <= 1'b0;
         rnw_q     <= 1'b0;
         err_pend  <= 1'b0;
         cnt       <= '0;
         IRDYn     <= 1'b1;
         LAST_BEAT <= 1'b0;
         DATA_LE   <= 1'b0;
         BEAT      <= 2'd0;
         TACKn     <= 1'b1;
         TEAn      <= 1'b1;
         RETRY     <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         state     <= state_d;
         cyc_q     <= PCI_CYCLEn;
         burst_q   <= burst_d;
         rnw_q     <= rnw_d;
         err_pend  <= err_pend_d;
         cnt       <= cnt_d;
         IRDYn     <= irdy_d;
         LAST_BEAT <= last_d;
         DATA_LE   <= le_d;
         BEAT      <= beat_d;
         TACKn     <= tack_d;
         TEAn      <= tea_d;
         RETRY     <= retry_d;
         DONE      <= done_d;
      end
   end
endmodule

// File: tb/tb_pci_data_phase.sv
// tb_pci_data_phase: directed self-checking bench for pci_data_phase
module tb_pci_data_phase;
   logic       CLK33 = 1'b0;
   logic       RESETn, PCI_CYCLEn, BURST, RnW, DEVSELn, TRDYn, STOPn;
   logic       IRDYn, LAST_BEAT, DATA_LE, TACKn, TEAn, RETRY, DONE;
   logic [1:0] BEAT;
   logic [8:0] outs;
   int         n_checks = 0;
   int         n_errors = 0;
   // outs = {IRDYn, LAST_BEAT, DATA_LE, BEAT[1:0], TACKn, TEAn, RETRY, DONE}
   localparam logic [8:0] O_IDLE = 9'b1_0_0_00_1_1_0_0;
   localparam logic [8:0] O_DONE = 9'b1_0_0_00_1_1_0_1;
   localparam logic [8:0] O_W1   = 9'b0_1_0_00_1_1_0_0;
   localparam logic [8:0] O_W0   = 9'b0_0_0_00_1_1_0_0;
   localparam logic [8:0] O_TEA  = 9'b0_1_0_00_1_0_0_0;
   pci_data_phase dut (
      .CLK33(CLK33), .RESETn(RESETn), .PCI_CYCLEn(PCI_CYCLEn), .BURST(BURST), .RnW(RnW),
      .DEVSELn(DEVSELn), .TRDYn(TRDYn), .STOPn(STOPn), .IRDYn(IRDYn), .LAST_BEAT(LAST_BEAT),
      .DATA_LE(DATA_LE), .BEAT(BEAT), .TACKn(TACKn), .TEAn(TEAn), .RETRY(RETRY), .DONE(DONE)
   );
   assign outs = {IRDYn, LAST_BEAT, DATA_LE, BEAT, TACKn, TEAn, RETRY, DONE};
   always #5 CLK33 = ~CLK33;
   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask
   task automatic step(input string tag, input logic cyc, input logic dev, input logic trdy,
                       input logic stop, input logic [8:0] exp);
      PCI_CYCLEn = cyc;
      DEVSELn    = dev;
      TRDYn      = trdy;
      STOPn      = stop;
      @(posedge CLK33);
      @(negedge CLK33);
      check(tag, outs, exp);
   endtask
   initial begin
      RESETn = 1'b0; PCI_CYCLEn = 1'b1; BURST = 1'b0; RnW = 1'b0;
      DEVSELn = 1'b1; TRDYn = 1'b1; STOPn = 1'b1;
      repeat (2) @(negedge CLK33);
      check("reset", outs, O_IDLE);
      RESETn = 1'b1;
      step("idle", 1, 1, 1, 1, O_IDLE);
      // single read
      BURST = 1'b0; RnW = 1'b1;
      step("rd_start",  0, 1, 1, 1, O_W1);
      step("rd_devsel", 0, 0, 1, 1, O_W1);
      step("rd_beat",   0, 0, 0, 1, 9'b0_1_1_00_0_1_0_0);
      step("rd_done",   0, 1, 1, 1, O_DONE);
      step("rd_hold",   0, 1, 1, 1, O_IDLE);
      step("rd_rel",    1, 1, 1, 1, O_IDLE);
      // burst write, DEVSELn and TRDYn on the same edge
      BURST = 1'b1; RnW = 1'b0;
      step("bw_start", 0, 1, 1, 1, O_W0);
      step("bw_beat0", 0, 0, 0, 1, 9'b0_0_0_01_0_1_0_0);
      step("bw_beat1", 0, 0, 0, 1, 9'b0_1_0_10_0_1_0_0);
      step("bw_beat2", 0, 0, 0, 1, 9'b0_1_0_11_0_1_0_0);
      step("bw_beat3", 0, 0, 0, 1, 9'b0_1_0_11_0_1_0_0);
      step("bw_done",  0, 1, 1, 1, O_DONE);
      step("bw_rel",   1, 1, 1, 1, O_IDLE);
      // master abort
      BURST = 1'b0; RnW = 1'b1;
      step("ma_start", 0, 1, 1, 1, O_W1);
      for (int i = 1; i < 5; i++) step($sformatf("ma_wait%0d", i), 0, 1, 1, 1, O_W1);
      step("ma_tea",  0, 1, 1, 1, O_TEA);
      step("ma_done", 0, 1, 1, 1, O_DONE);
      step("ma_rel",  1, 1, 1, 1, O_IDLE);
      // retry without data
      BURST = 1'b1; RnW = 1'b1;
      step("rt_start",  0, 1, 1, 1, O_W0);
      step("rt_devsel", 0, 0, 1, 1, O_W0);
      step("rt_stop",   0, 0, 1, 0, 9'b0_1_0_00_1_1_1_0);
      step("rt_done",   0, 1, 1, 1, O_DONE);
      step("rt_rel",    1, 1, 1, 1, O_IDLE);
      // disconnect with data on beat 1
      step("dc_start",  0, 1, 1, 1, O_W0);
      step("dc_devsel", 0, 0, 1, 1, O_W0);
      step("dc_beat0",  0, 0, 0, 1, 9'b0_0_1_01_0_1_0_0);
      step("dc_beat1",  0, 0, 0, 0, 9'b0_1_1_01_0_1_1_0);
      step("dc_done",   0, 1, 1, 1, O_DONE);
      step("dc_rel",    1, 1, 1, 1, O_IDLE);
      // target abort
      BURST = 1'b0;
      step("ta_start",  0, 1, 1, 1, O_W1);
      step("ta_devsel", 0, 0, 1, 1, O_W1);
      step("ta_stop",   0, 1, 1, 0, O_TEA);
      step("ta_done",   0, 1, 1, 1, O_DONE);
      step("ta_rel",    1, 1, 1, 1, O_IDLE);
      // TRDY latency timeout
      RnW = 1'b0;
      step("to_start",  0, 1, 1, 1, O_W1);
      step("to_devsel", 0, 0, 1, 1, O_W1);
      for (int i = 1; i < 16; i++) step($sformatf("to_wait%0d", i), 0, 0, 1, 1, O_W1);
      step("to_tea",  0, 0, 1, 1, O_TEA);
      step("to_done", 0, 1, 1, 1, O_DONE);
      step("to_rel",  1, 1, 1, 1, O_IDLE);
      // completed beat coinciding with target abort: TACK first, TEA next clock
      BURST = 1'b1;
      step("co_start",  0, 1, 1, 1, O_W0);
      step("co_devsel", 0, 0, 1, 1, O_W0);
      step("co_beat",   0, 1, 0, 0, 9'b0_1_0_00_0_1_0_0);
      step("co_tea",    0, 1, 1, 1, 9'b1_0_0_00_1_0_0_1);
      step("co_rel",    1, 1, 1, 1, O_IDLE);
      // asynchronous reset mid-burst at BEAT=2
      RnW = 1'b1;
      step("rs_start", 0, 1, 1, 1, O_W0);
      step("rs_beat0", 0, 0, 0, 1, 9'b0_0_1_01_0_1_0_0);
      step("rs_beat1", 0, 0, 0, 1, 9'b0_1_1_10_0_1_0_0);
      #2 RESETn = 1'b0;
      #1 check("rs_async", outs, O_IDLE);
      step("rs_held", 1, 1, 1, 1, O_IDLE);
      RESETn = 1'b1;
      step("rs_idle",  1, 1, 1, 1, O_IDLE);
      step("rs_nodone", 1, 1, 1, 1, O_IDLE);
      step("rs_restart", 0, 1, 1, 1, O_W0);
      step("rs_rbeat0",  0, 0, 0, 1, 9'b0_0_1_01_0_1_0_0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
